// File: rtl/mips_run_controller.sv
// Run-control unit for the MIPS cores: gates PC advance (free run, N-step, halt,
// hardware breakpoints, stop-on-exception, keys load), counts retired instructions and muxes probes.
module mips_run_controller #(
    parameter int unsigned WSIZE      = 32,
    parameter int unsigned NUM_BP     = 4,
    parameter int unsigned NUM_PROBES = 8,
    parameter int unsigned PSEL_W     = 3,
    parameter int unsigned STEP_W     = 8,
    parameter int unsigned ICNT_W     = 32,
    localparam int unsigned BP_W      = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        run,
    input  logic                        step_req,
    input  logic [STEP_W-1:0]           step_n,
    input  logic                        halt_req,
    input  logic                        stop_on_exc,
    input  logic                        exception,
    input  logic                        keys_input,
    input  logic [WSIZE-1:0]            pc,
    input  logic                        bp_we,
    input  logic [BP_W-1:0]             bp_idx,
    input  logic [WSIZE-1:0]            bp_addr,
    input  logic                        bp_valid,
    input  logic [NUM_PROBES*WSIZE-1:0] probe_bus,
    input  logic [PSEL_W-1:0]           probe_sel,
    output logic                        pc_we,
    output logic                        pc_sel_keys,
    output logic [1:0]                  state,
    output logic [BP_W-1:0]             bp_hit_idx,
    output logic [ICNT_W-1:0]           instr_count,
    output logic [WSIZE-1:0]            probe_data
);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic                mask_q, mask_d;
    logic [BP_W-1:0]     hit_idx_q, hit_idx_d;
    logic [ICNT_W-1:0]   icnt_q, icnt_d;
    logic [WSIZE-1:0]    probe_q, probe_d;
    logic [WSIZE-3:0]    bp_tag_q [NUM_BP];
    logic [NUM_BP-1:0]   bp_valid_q;

    logic                active, exc_stop, bp_hit, retire, keys_load;
    logic [BP_W-1:0]     bp_sel;
    logic                unused_bits;

    // Word-aligned compare: the low address bits never take part in a match.
    assign unused_bits = ^{bp_addr[1:0], pc[1:0]};

    always_comb begin
        bp_hit = 1'b0;
        bp_sel = '0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (!bp_hit && !mask_q && bp_valid_q[i] && (bp_tag_q[i] == pc[WSIZE-1:2])) begin
                bp_hit = 1'b1;
                bp_sel = BP_W'(i);
            end
        end
    end

    assign active    = (state_q == S_RUN) || (state_q == S_STEP);
    assign exc_stop  = stop_on_exc & exception;
    assign retire    = active & ~halt_req & ~bp_hit & ~exc_stop;
    assign keys_load = ~active & keys_input & ~step_req & ~run;

    assign pc_we       = reset & (retire | keys_load);
    assign pc_sel_keys = reset & keys_load;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        hit_idx_d = hit_idx_q;
        icnt_d    = icnt_q;
        if (!active) begin
            if (step_req) begin
                state_d = S_STEP;
                cnt_d   = (step_n == '0) ? STEP_W'(1) : step_n;
                mask_d  = 1'b1;
            end else if (run) begin
                state_d = S_RUN;
                mask_d  = 1'b1;
            end
        end else if (halt_req) begin
            state_d = S_HALT;
        end else if (bp_hit) begin
            state_d   = S_BREAK;
            hit_idx_d = bp_sel;
        end else if (exc_stop) begin
            state_d = S_HALT;
        end else begin
            // Retiring cycle: the final step / dropped run still lets this instruction complete.
            mask_d = 1'b0;
            if (state_q == S_STEP) begin
                cnt_d = cnt_q - STEP_W'(1);
                if (cnt_q <= STEP_W'(1)) state_d = S_HALT;
            end else if (!run) begin
                state_d = S_HALT;
            end
            if (icnt_q != '1) icnt_d = icnt_q + ICNT_W'(1);
        end
    end

    always_comb begin
        probe_d = '0;
        for (int unsigned k = 0; k < NUM_PROBES; k++) begin
            if (probe_sel == PSEL_W'(k)) probe_d = probe_bus[k*WSIZE +: WSIZE];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_HALT;
            cnt_q      <= '0;
            mask_q     <= 1'b1;
            hit_idx_q  <= '0;
            icnt_q     <= '0;
            probe_q    <= '0;
            bp_valid_q <= '0;
            for (int unsigned i = 0; i < NUM_BP; i++) bp_tag_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            hit_idx_q <= hit_idx_d;
            icnt_q    <= icnt_d;
            probe_q   <= probe_d;
            if (bp_we) begin
                for (int unsigned i = 0; i < NUM_BP; i++) begin
                    if (bp_idx == BP_W'(i)) begin
                        bp_tag_q[i]   <= bp_addr[WSIZE-1:2];
                        bp_valid_q[i] <= bp_valid;
                    end
                end
            end
        end
    end

    assign state       = state_q;
    assign bp_hit_idx  = hit_idx_q;
    assign instr_count = icnt_q;
    assign probe_data  = probe_q;

endmodule

// File: tb/tb_mips_run_controller.sv
// Scoreboard bench for mips_run_controller: expected PC writes are queued by the stimulus
// and matched by a monitor on every cycle where pc_we is asserted.
module tb_mips_run_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        run, step_req, halt_req, stop_on_exc, exception, keys_input;
    logic [7:0]  step_n;
    logic [31:0] pc;
    logic        bp_we, bp_valid;
    logic [1:0]  bp_idx;
    logic [31:0] bp_addr;
    logic [255:0] probe_bus;
    logic [191:0] probe_bus6;
    logic [2:0]  probe_sel;

    logic        pc_we, pc_sel_keys;
    logic [1:0]  state;
    logic [1:0]  bp_hit_idx;
    logic [31:0] instr_count, probe_data;

    logic        u6_pc_we, u6_pc_sel_keys;
    logic [1:0]  u6_state, u6_bp_hit_idx;
    logic [31:0] u6_instr_count, u6_probe_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        keys;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    mips_run_controller #(.WSIZE(32), .NUM_BP(4), .NUM_PROBES(8), .PSEL_W(3), .STEP_W(8), .ICNT_W(32)) u_dut (
        .clock(clk), .reset(reset), .run(run), .step_req(step_req), .step_n(step_n),
        .halt_req(halt_req), .stop_on_exc(stop_on_exc), .exception(exception),
        .keys_input(keys_input), .pc(pc), .bp_we(bp_we), .bp_idx(bp_idx),
        .bp_addr(bp_addr), .bp_valid(bp_valid), .probe_bus(probe_bus), .probe_sel(probe_sel),
        .pc_we(pc_we), .pc_sel_keys(pc_sel_keys), .state(state), .bp_hit_idx(bp_hit_idx),
        .instr_count(instr_count), .probe_data(probe_data)
    );

    mips_run_controller #(.WSIZE(32), .NUM_BP(4), .NUM_PROBES(6), .PSEL_W(3), .STEP_W(8), .ICNT_W(32)) u_dut6 (
        .clock(clk), .reset(reset), .run(run), .step_req(step_req), .step_n(step_n),
        .halt_req(halt_req), .stop_on_exc(stop_on_exc), .exception(exception),
        .keys_input(keys_input), .pc(pc), .bp_we(bp_we), .bp_idx(bp_idx),
        .bp_addr(bp_addr), .bp_valid(bp_valid), .probe_bus(probe_bus6), .probe_sel(probe_sel),
        .pc_we(u6_pc_we), .pc_sel_keys(u6_pc_sel_keys), .state(u6_state), .bp_hit_idx(u6_bp_hit_idx),
        .instr_count(u6_instr_count), .probe_data(u6_probe_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every asserted pc_we must match the next queued expectation.
    always @(negedge clk) begin
        if (pc_we === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pc_we: got pc_we=1 at pc 0x%08h expected pc_we=0", pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pc_we_pc", pc, e.pc);
                chk("pc_sel_keys", {31'b0, pc_sel_keys}, {31'b0, e.keys});
            end
        end
    end

    task automatic cyc(input logic [31:0] p, input bit we, input bit keys);
        pc = p;
        if (we) q.push_back('{pc: p, keys: keys});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; run = 0; step_req = 0; halt_req = 0; stop_on_exc = 0; exception = 0;
        keys_input = 1'b1; step_n = 0; pc = 0; bp_we = 0; bp_valid = 0; bp_idx = 0; bp_addr = 0;
        probe_sel = 0;
        probe_bus = '0;
        for (int k = 0; k < 8; k++) probe_bus[k*32 +: 32] = 32'h1000_0000 + 32'(k);
        probe_bus[5*32 +: 32] = 32'hDEAD_BEEF;
        for (int k = 0; k < 6; k++) probe_bus6[k*32 +: 32] = 32'h2000_0000 + 32'(k);
        #3;
        chk("reset_pc_we", {31'b0, pc_we}, 32'd0);
        chk("reset_state", {30'b0, state}, 32'd0);
        chk("reset_icnt", instr_count, 32'd0);
        chk("reset_probe", probe_data, 32'd0);
        chk("reset_hit_idx", {30'b0, bp_hit_idx}, 32'd0);
        keys_input = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        // Free run, 10 instructions, then drop run (last one retires)
        run = 1'b1;
        cyc(0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(32'(i * 4), 1, 0);
        chk("run_icnt10", instr_count, 32'd10);
        chk("run_state", {30'b0, state}, 32'd1);
        run = 1'b0;
        cyc(40, 1, 0);
        chk("run_drop_state", {30'b0, state}, 32'd0);
        chk("run_drop_icnt", instr_count, 32'd11);
        cyc(44, 0, 0);

        // Step 3, then step 0 (treated as 1)
        step_req = 1'b1; step_n = 8'd3;
        cyc(44, 0, 0);
        step_req = 1'b0;
        chk("step_state", {30'b0, state}, 32'd2);
        cyc(44, 1, 0); cyc(48, 1, 0); cyc(52, 1, 0);
        cyc(56, 0, 0);
        chk("step3_state", {30'b0, state}, 32'd0);
        chk("step3_icnt", instr_count, 32'd14);
        step_req = 1'b1; step_n = 8'd0;
        cyc(56, 0, 0);
        step_req = 1'b0;
        cyc(56, 1, 0);
        cyc(60, 0, 0);
        chk("step0_state", {30'b0, state}, 32'd0);
        chk("step0_icnt", instr_count, 32'd15);

        // Breakpoints: slot2 and slot3 both at 0x10 (low bits ignored), slot2 must win
        bp_we = 1'b1; bp_valid = 1'b1; bp_idx = 2'd2; bp_addr = 32'h12;
        cyc(60, 0, 0);
        bp_idx = 2'd3; bp_addr = 32'h10;
        cyc(60, 0, 0);
        bp_we = 1'b0;
        run = 1'b1;
        cyc(8, 0, 0);
        cyc(8, 1, 0); cyc(12, 1, 0);
        cyc(16, 0, 0);
        chk("bp_state", {30'b0, state}, 32'd3);
        chk("bp_hit_idx", {30'b0, bp_hit_idx}, 32'd2);
        chk("bp_icnt", instr_count, 32'd17);
        run = 1'b0;
        cyc(16, 0, 0);
        run = 1'b1;
        cyc(16, 0, 0);
        cyc(16, 1, 0); cyc(20, 1, 0);
        halt_req = 1'b1;
        cyc(24, 0, 0);
        halt_req = 1'b0; run = 1'b0;
        chk("halt_state", {30'b0, state}, 32'd0);
        chk("bp_resume_icnt", instr_count, 32'd19);

        // Stop on exception enabled, then disabled
        stop_on_exc = 1'b1; run = 1'b1;
        cyc(32'h100, 0, 0);
        cyc(32'h100, 1, 0);
        exception = 1'b1; run = 1'b0;
        cyc(32'h104, 0, 0);
        exception = 1'b0;
        chk("exc_state", {30'b0, state}, 32'd0);
        chk("exc_icnt", instr_count, 32'd20);
        stop_on_exc = 1'b0; run = 1'b1;
        cyc(32'h104, 0, 0);
        exception = 1'b1;
        cyc(32'h104, 1, 0);
        exception = 1'b0; run = 1'b0;
        cyc(32'h108, 1, 0);
        chk("noexc_state", {30'b0, state}, 32'd0);
        chk("noexc_icnt", instr_count, 32'd22);

        // Keys load when stopped, ignored while running
        keys_input = 1'b1;
        cyc(32'h200, 1, 1);
        keys_input = 1'b0;
        chk("keys_icnt", instr_count, 32'd22);
        chk("keys_state", {30'b0, state}, 32'd0);
        run = 1'b1;
        cyc(0, 0, 0);
        keys_input = 1'b1;
        cyc(32'h300, 1, 0);
        keys_input = 1'b0; run = 1'b0;
        cyc(32'h304, 1, 0);
        chk("keys_run_icnt", instr_count, 32'd24);

        // Probe mux
        probe_sel = 3'd5;
        cyc(32'h304, 0, 0);
        chk("probe_ch5", probe_data, 32'hDEAD_BEEF);
        chk("probe6_ch5", u6_probe_data, 32'h2000_0005);
        probe_sel = 3'd7;
        cyc(32'h304, 0, 0);
        chk("probe_ch7", probe_data, 32'h1000_0007);
        chk("probe6_sel7", u6_probe_data, 32'd0);

        // Reset asserted while running
        run = 1'b1;
        cyc(32'h400, 0, 0);
        cyc(32'h400, 1, 0);
        pc = 32'h404;
        reset = 1'b0;
        #1;
        chk("midreset_pc_we", {31'b0, pc_we}, 32'd0);
        chk("midreset_state", {30'b0, state}, 32'd0);
        chk("midreset_icnt", instr_count, 32'd0);
        @(posedge clk); #1;
        run = 1'b0; reset = 1'b1;
        cyc(32'h404, 0, 0);
        cyc(32'h404, 0, 0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
